// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictors: counter encodings, the PHT index hash
// and the default counter reset value.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr2_e;

   localparam int BP_CTR_INIT = int'(WNT);

   // Returns the full-width hash; callers keep the low index bits.
   // The pc>>2 drops the word-offset bits.
   function automatic logic [31:0] bp_idx(input logic [31:0] pc, input logic [31:0] ghr_ext);
      return (pc >> 2) ^ ghr_ext;
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for one saturating direction counter; force_max models an
// unconditional jump.
module bp_sat_ctr #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   input  logic             force_max,
   output logic [CTR_W-1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (force_max) begin
         ctr_next = '1;
      end else if (taken) begin
         if (ctr != '1) ctr_next = ctr + CTR_W'(1);
      end else begin
         if (ctr != '0) ctr_next = ctr - CTR_W'(1);
      end
   end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: PHT of saturating counters indexed by PC ^ global history,
// with a speculative GHR repaired from the EX snapshot on a mispredict.
module gshare_branch_predictor
   import bp_pkg::*;
#(
   parameter int PHT_IDX_W = 10,
   parameter int GHR_W     = 8,
   parameter int CTR_W     = 2,
   parameter int CTR_INIT  = BP_CTR_INIT
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pred_valid,
   input  logic [31:0]      pred_pc,
   output logic             pred_taken,
   output logic [GHR_W-1:0] pred_ghr,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_taken,
   input  logic             upd_is_jump,
   input  logic             upd_mispredict
);

   localparam int PHT_SIZE = 1 << PHT_IDX_W;

   logic [CTR_W-1:0]     pht [PHT_SIZE];
   logic [GHR_W-1:0]     ghr;
   logic [PHT_IDX_W-1:0] rd_idx;
   logic [PHT_IDX_W-1:0] wr_idx;
   logic [CTR_W-1:0]     wr_ctr_next;

   assign rd_idx     = PHT_IDX_W'(bp_idx(pred_pc, 32'(ghr)));
   assign wr_idx     = PHT_IDX_W'(bp_idx(upd_pc, 32'(upd_ghr)));
   assign pred_taken = pht[rd_idx][CTR_W-1];
   assign pred_ghr   = ghr;

   bp_sat_ctr #(
      .CTR_W(CTR_W)
   ) u_sat_ctr (
      .ctr      (pht[wr_idx]),
      .taken    (upd_taken),
      .force_max(upd_is_jump),
      .ctr_next (wr_ctr_next)
   );

   // Reset wins over any concurrent update so no stale write lands after reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < PHT_SIZE; i++) begin
            pht[i] <= CTR_W'(CTR_INIT);
         end
      end else if (upd_valid) begin
         pht[wr_idx] <= wr_ctr_next;
      end
   end

   // A mispredict repair replaces the same-cycle speculative shift because PF is being flushed.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ghr <= '0;
      end else if (upd_valid && upd_mispredict) begin
         ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
      end else if (pred_valid) begin
         ghr <= {ghr[GHR_W-2:0], pred_taken};
      end
   end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: a behavioural PHT/GHR model feeds a
// scoreboard queue that is compared against the DUT outputs each cycle.
module tb_gshare_branch_predictor;

   typedef struct packed {
      logic       taken;
      logic [7:0] ghr;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [7:0]  pred_ghr;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [7:0]  upd_ghr;
   logic        upd_taken;
   logic        upd_is_jump;
   logic        upd_mispredict;

   int   checkCount;
   int   errorCount;
   exp_t scoreboard[$];
   logic [1:0] mPht [1024];
   logic [7:0] mGhr;

   gshare_branch_predictor dut (
      .clk           (clk),
      .resetn        (resetn),
      .pred_valid    (pred_valid),
      .pred_pc       (pred_pc),
      .pred_taken    (pred_taken),
      .pred_ghr      (pred_ghr),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_ghr       (upd_ghr),
      .upd_taken     (upd_taken),
      .upd_is_jump   (upd_is_jump),
      .upd_mispredict(upd_mispredict)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [9:0] modelIdx(input logic [31:0] pc, input logic [7:0] g);
      return pc[11:2] ^ {2'b00, g};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // One cycle: drive at the negedge, check 1ns later, then advance the model across the posedge.
   task automatic applyStimulus(input string tag, input logic rstN, input logic pv, input logic [31:0] ppc,
                                input logic uv, input logic [31:0] upc, input logic [7:0] ughr,
                                input logic ut, input logic uj, input logic um);
      exp_t e;
      exp_t got;
      logic [9:0] wi;
      resetn = rstN; pred_valid = pv; pred_pc = ppc;
      upd_valid = uv; upd_pc = upc; upd_ghr = ughr;
      upd_taken = ut; upd_is_jump = uj; upd_mispredict = um;
      e.taken = mPht[modelIdx(ppc, mGhr)][1];
      e.ghr   = mGhr;
      scoreboard.push_back(e);
      #1;
      got = scoreboard.pop_front();
      checkOutput({tag, ".taken"}, 32'(pred_taken), 32'(got.taken));
      checkOutput({tag, ".ghr"}, 32'(pred_ghr), 32'(got.ghr));
      if (!rstN) begin
         for (int i = 0; i < 1024; i++) mPht[i] = 2'd1;
         mGhr = 8'h00;
      end else begin
         if (uv) begin
            wi = modelIdx(upc, ughr);
            if (uj) mPht[wi] = 2'd3;
            else if (ut && mPht[wi] != 2'd3) mPht[wi] = mPht[wi] + 2'd1;
            else if (!ut && mPht[wi] != 2'd0) mPht[wi] = mPht[wi] - 2'd1;
         end
         if (uv && um) mGhr = {ughr[6:0], ut};
         else if (pv) mGhr = {mGhr[6:0], e.taken};
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      applyStimulus("reset0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("reset1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // Update with the read port aimed at the same pc to exercise read-old-on-write.
   task automatic doUpdate(input string tag, input logic [31:0] pc, input logic [7:0] g,
                           input logic t, input logic j, input logic m);
      applyStimulus(tag, 1'b1, 1'b0, pc, 1'b1, pc, g, t, j, m);
   endtask

   task automatic probe(input string tag, input logic [9:0] idx);
      applyStimulus(tag, 1'b1, 1'b0, {20'h0, idx ^ {2'b00, mGhr}, 2'b00},
                    1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      mGhr = 8'h00;
      for (int i = 0; i < 1024; i++) mPht[i] = 2'd1;
      resetn = 1'b0; pred_valid = 1'b0; pred_pc = 32'h0;
      upd_valid = 1'b0; upd_pc = 32'h0; upd_ghr = 8'h00;
      upd_taken = 1'b0; upd_is_jump = 1'b0; upd_mispredict = 1'b0;
      @(negedge clk);

      doReset();
      applyStimulus("rst_pred", 1'b1, 1'b0, 32'h0040_0010, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_taken_const", 32'(pred_taken), 32'h0);
      checkOutput("rst_ghr_const", 32'(pred_ghr), 32'h00);

      // Saturation on pc 0x100 (idx 0x40).
      doUpdate("tk1", 32'h100, 8'h00, 1'b1, 1'b0, 1'b0);
      doUpdate("tk2", 32'h100, 8'h00, 1'b1, 1'b0, 1'b0);
      probe("sat_hi", 10'h040);
      checkOutput("sat_hi_const", 32'(pred_taken), 32'h1);
      doUpdate("tk3", 32'h100, 8'h00, 1'b1, 1'b0, 1'b0);
      probe("no_wrap", 10'h040);
      for (int i = 0; i < 5; i++) doUpdate("nt", 32'h100, 8'h00, 1'b0, 1'b0, 1'b0);
      probe("sat_lo", 10'h040);
      doUpdate("tk_after0", 32'h100, 8'h00, 1'b1, 1'b0, 1'b0);
      probe("no_underflow", 10'h040);
      doUpdate("tk_after1", 32'h100, 8'h00, 1'b1, 1'b0, 1'b0);
      probe("climb", 10'h040);

      // Speculative history shift with predictions 1,0,1.
      doReset();
      doUpdate("trainA", 32'h080, 8'h00, 1'b1, 1'b0, 1'b0);
      doUpdate("trainC", 32'h108, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus("shift0", 1'b1, 1'b1, 32'h080, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("shift1", 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("shift2", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      probe("ghr_final", 10'h000);
      checkOutput("ghr_final_const", 32'(pred_ghr), 32'h05);

      // Repair beats the same-cycle speculative shift.
      applyStimulus("repair", 1'b1, 1'b1, 32'h080, 1'b1, 32'h300, 8'h3A, 1'b1, 1'b0, 1'b1);
      probe("repair_chk", 10'h000);
      checkOutput("repair_const", 32'(pred_ghr), 32'h75);

      // Aliasing: (0x004, 0x01) and (0x000, 0x00) share idx 0.
      doReset();
      doUpdate("alias_upd", 32'h004, 8'h01, 1'b1, 1'b0, 1'b0);
      applyStimulus("alias_rd", 1'b1, 1'b0, 32'h000, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("alias_const", 32'(pred_taken), 32'h1);

      // Jump forces max and leaves GHR alone.
      doReset();
      doUpdate("to_zero", 32'h014, 8'h00, 1'b0, 1'b0, 1'b0);
      doUpdate("jump", 32'h014, 8'h00, 1'b0, 1'b1, 1'b0);
      probe("jump_max", 10'h005);
      checkOutput("jump_ghr_const", 32'(pred_ghr), 32'h00);
      doUpdate("jump_dec", 32'h014, 8'h00, 1'b0, 1'b0, 1'b0);
      probe("jump_was3", 10'h005);

      // Reset during an update must leave CTR_INIT.
      doUpdate("pre_rst1", 32'h01C, 8'h00, 1'b1, 1'b0, 1'b0);
      doUpdate("pre_rst2", 32'h01C, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus("rst_upd", 1'b0, 1'b1, 32'h01C, 1'b1, 32'h01C, 8'h00, 1'b1, 1'b0, 1'b1);
      probe("post_rst", 10'h007);
      checkOutput("post_rst_const", 32'(pred_taken), 32'h0);
      doUpdate("post_rst_tk", 32'h01C, 8'h00, 1'b1, 1'b0, 1'b0);
      probe("post_rst_init1", 10'h007);

      // Random traffic over a small index window to provoke collisions.
      for (int n = 0; n < 60; n++) begin
         applyStimulus("rand", 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                       1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                       8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
